// File: rtl/ntt_core_gf64_common_param_pkg.sv
// ============================================================================
// ntt_core_gf64_common_param_pkg : shared sizes, framer state, network ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package ntt_core_gf64_common_param_pkg;

    localparam int PSI       = 2;
    localparam int R         = 2;
    localparam int BPBS_ID_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } framer_state_e;

    // Column/network side-band carried alongside every beat.
    typedef struct packed {
        logic                 sob;
        logic                 eob;
        logic                 sol;
        logic                 eol;
        logic                 sos;
        logic                 eos;
        logic [BPBS_ID_W-1:0] pbs_id;
    } ntw_ctrl_t;

    // Counter width for a range of n values; a 1-entry range still needs a bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_core_gf64_ntw_framer_if.sv
// ============================================================================
// ntt_core_gf64_ntw_framer_if : command, input stream and framed column bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ntt_core_gf64_ntw_framer_if
    import ntt_core_gf64_common_param_pkg::*;
#(
    parameter int OP_W = 66
) ();

    logic                           cmd_vld;
    logic                           cmd_rdy;
    logic [BPBS_ID_W-1:0]           cmd_pbs_nb_m1;
    logic [PSI*R-1:0][OP_W-1:0]     in_data;
    logic                           in_vld;
    logic                           in_rdy;
    logic [PSI*R-1:0][OP_W-1:0]     out_data;
    logic [PSI*R-1:0]               out_avail;
    logic                           out_sob;
    logic                           out_eob;
    logic                           out_sol;
    logic                           out_eol;
    logic                           out_sos;
    logic                           out_eos;
    logic [BPBS_ID_W-1:0]           out_pbs_id;
    logic                           busy;

    // The framer is the transmitting end of the column protocol.
    modport master (
        input  cmd_vld, cmd_pbs_nb_m1, in_data, in_vld,
        output cmd_rdy, in_rdy, out_data, out_avail,
        output out_sob, out_eob, out_sol, out_eol, out_sos, out_eos,
        output out_pbs_id, busy
    );

    modport slave (
        output cmd_vld, cmd_pbs_nb_m1, in_data, in_vld,
        input  cmd_rdy, in_rdy, out_data, out_avail,
        input  out_sob, out_eob, out_sol, out_eol, out_sos, out_eos,
        input  out_pbs_id, busy
    );

endinterface

`default_nettype wire

// File: rtl/ntt_core_gf64_wrap_cnt.sv
// ============================================================================
// ntt_core_gf64_wrap_cnt : 0..max wrapping counter with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_core_gf64_wrap_cnt #(
    parameter int MAX_W = 4
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [MAX_W-1:0] max,
    output logic [MAX_W-1:0] cnt,
    output logic             last
);

    logic [MAX_W-1:0] cnt_q;
    logic [MAX_W-1:0] cnt_d;

    assign last = (cnt_q == max);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last ? '0 : cnt_q + MAX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_core_gf64_ntw_framer.sv
// ============================================================================
// ntt_core_gf64_ntw_framer : frames a PBS batch into the radix-column protocol
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_core_gf64_ntw_framer
    import ntt_core_gf64_common_param_pkg::*;
#(
    parameter int OP_W        = 66,
    parameter int STG_ITER_NB = 32,
    parameter int LVL_NB      = 2
) (
    input  logic                        clk,
    input  logic                        a_rst,
    ntt_core_gf64_ntw_framer_if.master  bus
);

    localparam int STG_W = cnt_w(STG_ITER_NB);
    localparam int LVL_W = cnt_w(LVL_NB);
    localparam logic [STG_W-1:0] STG_MAX = STG_W'(STG_ITER_NB - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LVL_NB - 1);

    framer_state_e              state_q;
    framer_state_e              state_d;
    logic [BPBS_ID_W-1:0]       pbs_nb_m1_q;
    logic [BPBS_ID_W-1:0]       pbs_nb_m1_d;
    logic                       avail_q;
    logic                       avail_d;
    ntw_ctrl_t                  ctrl_q;
    ntw_ctrl_t                  ctrl_d;
    logic [PSI*R-1:0][OP_W-1:0] data_q;
    logic [PSI*R-1:0][OP_W-1:0] data_d;

    logic                       cmd_rdy;
    logic                       in_rdy;
    logic                       cmd_acc;
    logic                       beat;
    logic [STG_W-1:0]           stg_cnt;
    logic [LVL_W-1:0]           lvl_cnt;
    logic [BPBS_ID_W-1:0]       pbs_cnt;
    logic                       stg_last;
    logic                       lvl_last;
    logic                       pbs_last;
    ntw_ctrl_t                  ctrl_cur;

    always_comb begin
        state_d = state_q;
        cmd_rdy = 1'b0;
        in_rdy  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (bus.cmd_vld) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                in_rdy = 1'b1;
                if (bus.in_vld && ctrl_cur.eob) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cmd_acc = cmd_rdy && bus.cmd_vld;
    assign beat    = in_rdy && bus.in_vld;

    ntt_core_gf64_wrap_cnt #(.MAX_W(STG_W)) u_stg_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .inc   (beat),
        .clr   (cmd_acc),
        .max   (STG_MAX),
        .cnt   (stg_cnt),
        .last  (stg_last)
    );

    ntt_core_gf64_wrap_cnt #(.MAX_W(LVL_W)) u_lvl_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .inc   (beat && stg_last),
        .clr   (cmd_acc),
        .max   (LVL_MAX),
        .cnt   (lvl_cnt),
        .last  (lvl_last)
    );

    // The PBS range comes from the latched command, not from a constant.
    ntt_core_gf64_wrap_cnt #(.MAX_W(BPBS_ID_W)) u_pbs_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .inc   (beat && stg_last && lvl_last),
        .clr   (cmd_acc),
        .max   (pbs_nb_m1_q),
        .cnt   (pbs_cnt),
        .last  (pbs_last)
    );

    always_comb begin
        ctrl_cur        = '0;
        ctrl_cur.sos    = (stg_cnt == '0);
        ctrl_cur.eos    = stg_last;
        ctrl_cur.sol    = ctrl_cur.sos && (lvl_cnt == '0);
        ctrl_cur.eol    = ctrl_cur.eos && lvl_last;
        ctrl_cur.sob    = ctrl_cur.sol && (pbs_cnt == '0);
        ctrl_cur.eob    = ctrl_cur.eol && pbs_last;
        ctrl_cur.pbs_id = pbs_cnt;
    end

    // Flags only live for the cycle of a beat; data and pbs_id hold across gaps.
    always_comb begin
        pbs_nb_m1_d = cmd_acc ? bus.cmd_pbs_nb_m1 : pbs_nb_m1_q;
        avail_d     = beat;
        data_d      = beat ? bus.in_data : data_q;
        ctrl_d      = '0;
        ctrl_d.pbs_id = ctrl_q.pbs_id;
        if (beat) begin
            ctrl_d = ctrl_cur;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            pbs_nb_m1_q <= '0;
            avail_q     <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
        end else begin
            pbs_nb_m1_q <= pbs_nb_m1_d;
            avail_q     <= avail_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
        end
    end

    assign bus.cmd_rdy    = cmd_rdy;
    assign bus.in_rdy     = in_rdy;
    assign bus.busy       = (state_q == RUN);
    assign bus.out_avail  = {(PSI*R){avail_q}};
    assign bus.out_data   = data_q;
    assign bus.out_sob    = ctrl_q.sob;
    assign bus.out_eob    = ctrl_q.eob;
    assign bus.out_sol    = ctrl_q.sol;
    assign bus.out_eol    = ctrl_q.eol;
    assign bus.out_sos    = ctrl_q.sos;
    assign bus.out_eos    = ctrl_q.eos;
    assign bus.out_pbs_id = ctrl_q.pbs_id;

endmodule

`default_nettype wire

// File: tb/tb_ntt_core_gf64_ntw_framer.sv
// ============================================================================
// tb_ntt_core_gf64_ntw_framer : batch-position model checked every cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_core_gf64_ntw_framer;
    import ntt_core_gf64_common_param_pkg::*;

    localparam int OP_W = 66;
    localparam int S    = 4;
    localparam int L    = 2;
    localparam int NL   = PSI * R;

    logic clk   = 1'b0;
    logic a_rst = 1'b1;
    always #5 clk = ~clk;

    ntt_core_gf64_ntw_framer_if #(.OP_W(OP_W)) ntw ();
    ntt_core_gf64_ntw_framer_if #(.OP_W(OP_W)) deg ();

    ntt_core_gf64_ntw_framer #(.OP_W(OP_W), .STG_ITER_NB(S), .LVL_NB(L)) u_dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (ntw)
    );

    ntt_core_gf64_ntw_framer #(.OP_W(OP_W), .STG_ITER_NB(1), .LVL_NB(1)) u_deg (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (deg)
    );

    typedef struct {
        logic [5:0]  fl;   // {sob,eob,sol,eol,sos,eos}
        int          pbs;
        logic [63:0] d0;
        int          cyc;
    } obs_t;

    obs_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   tag   = 0;

    // Model: a batch is a flat run of beats; flags follow from the beat's position.
    bit                         m_run;
    int                         m_b;
    int                         m_total;
    int                         m_pos;
    logic                       exp_avail;
    logic [5:0]                 exp_fl;
    int                         exp_pbs;
    logic [NL-1:0][OP_W-1:0]    exp_data;

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            m_run = 1'b0; m_b = 0; m_total = 0;
            exp_avail = 1'b0; exp_fl = '0; exp_pbs = 0; exp_data = '0;
        end else if (!m_run) begin
            exp_avail = 1'b0; exp_fl = '0;
            if (ntw.cmd_vld) begin
                m_run   = 1'b1;
                m_b     = 0;
                m_total = (int'(ntw.cmd_pbs_nb_m1) + 1) * S * L;
            end
        end else begin
            exp_avail = 1'b0; exp_fl = '0;
            if (ntw.in_vld) begin
                m_pos     = m_b % (S * L);
                exp_fl[1] = (m_b % S) == 0;
                exp_fl[0] = (m_b % S) == S - 1;
                exp_fl[3] = m_pos == 0;
                exp_fl[2] = m_pos == S * L - 1;
                exp_fl[5] = m_b == 0;
                exp_fl[4] = m_b == m_total - 1;
                exp_avail = 1'b1;
                exp_pbs   = m_b / (S * L);
                exp_data  = ntw.in_data;
                m_b++;
                if (m_b == m_total) m_run = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [5:0] flags_of(input bit is_deg);
        if (is_deg)
            return {deg.out_sob, deg.out_eob, deg.out_sol, deg.out_eol, deg.out_sos, deg.out_eos};
        return {ntw.out_sob, ntw.out_eob, ntw.out_sol, ntw.out_eol, ntw.out_sos, ntw.out_eos};
    endfunction

    task automatic compare_cycle();
        chk("avail",   512'(ntw.out_avail),  512'({NL{exp_avail}}));
        chk("flags",   512'(flags_of(1'b0)), 512'(exp_fl));
        chk("pbs_id",  512'(ntw.out_pbs_id), 512'(exp_pbs));
        chk("data",    512'(ntw.out_data),   512'(exp_data));
        chk("busy",    512'(ntw.busy),       512'(m_run));
        chk("cmd_rdy", 512'(ntw.cmd_rdy),    512'(!m_run));
        chk("in_rdy",  512'(ntw.in_rdy),     512'(m_run));
        if (ntw.out_avail[0]) begin
            obs_q.push_back('{fl: flags_of(1'b0), pbs: int'(ntw.out_pbs_id),
                              d0: ntw.out_data[0][63:0], cyc: cycle});
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!a_rst) compare_cycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic longint unsigned mask_of(input int base, input int n, input int b);
        longint unsigned m = 0;
        for (int k = 0; k < n; k++)
            if (base + k < obs_q.size() && obs_q[base + k].fl[b]) m |= (64'd1 << k);
        return m;
    endfunction

    // hold_nb >= 0 raises the next command together with the final beat.
    task automatic run_batch(input int nb_m1, input int duty, input int pulse_at,
                             input int hold_nb, output int base);
        int total;
        int sent;
        int guard;
        bit vld;
        total = (nb_m1 + 1) * S * L;
        sent  = 0;
        guard = 0;
        ntw.cmd_vld       = 1'b1;
        ntw.cmd_pbs_nb_m1 = BPBS_ID_W'(nb_m1);
        step();
        ntw.cmd_vld = 1'b0;
        chk("cmd_accept_busy", 512'(ntw.busy), 512'(1));
        base = obs_q.size();
        while (sent < total && guard < 2000) begin
            vld        = ($urandom_range(0, 99) < duty);
            ntw.in_vld = vld;
            for (int l = 0; l < NL; l++)
                ntw.in_data[l] = vld ? OP_W'(tag * NL + l) : OP_W'({$urandom(), $urandom()});
            ntw.cmd_vld = (sent == pulse_at) || (vld && sent == total - 1 && hold_nb >= 0);
            ntw.cmd_pbs_nb_m1 = (sent == pulse_at) ? BPBS_ID_W'(5)
                              : (hold_nb >= 0) ? BPBS_ID_W'(hold_nb) : BPBS_ID_W'(nb_m1);
            step();
            if (vld) begin
                sent++;
                tag++;
            end
            guard++;
        end
        if (sent < total) begin
            n_cmp++;
            n_err++;
            $display("FAIL batch_timeout: actual=%0d beats required=%0d", sent, total);
        end
        ntw.in_vld  = 1'b0;
        ntw.cmd_vld = (hold_nb >= 0);
        chk("cmd_rdy_after_eob", 512'(ntw.cmd_rdy), 512'(1));
    endtask

    int base, base2, t0;

    initial begin
        ntw.cmd_vld = 1'b0; ntw.cmd_pbs_nb_m1 = '0; ntw.in_vld = 1'b0; ntw.in_data = '0;
        deg.cmd_vld = 1'b0; deg.cmd_pbs_nb_m1 = '0; deg.in_vld = 1'b0; deg.in_data = '0;

        // Reset / idle
        #12;
        chk("rst_avail", 512'(ntw.out_avail),  512'(0));
        chk("rst_flags", 512'(flags_of(1'b0)), 512'(0));
        chk("rst_data",  512'(ntw.out_data),   512'(0));
        chk("rst_pbs",   512'(ntw.out_pbs_id), 512'(0));
        chk("rst_busy",  512'(ntw.busy),       512'(0));
        @(posedge clk); #1;
        a_rst = 1'b0;
        step();
        chk("idle_cmd_rdy", 512'(ntw.cmd_rdy), 512'(1));
        chk("idle_in_rdy",  512'(ntw.in_rdy),  512'(0));

        // Single PBS, continuous
        tag = 0; t0 = tag;
        run_batch(0, 100, -1, -1, base);
        step();
        chk("s_count", 512'(obs_q.size() - base), 512'(8));
        chk("s_consecutive", 512'(obs_q[base + 7].cyc - obs_q[base].cyc), 512'(7));
        chk("s_sos", 512'(mask_of(base, 8, 1)), 512'(8'h11));
        chk("s_eos", 512'(mask_of(base, 8, 0)), 512'(8'h88));
        chk("s_sol", 512'(mask_of(base, 8, 3)), 512'(8'h01));
        chk("s_sob", 512'(mask_of(base, 8, 5)), 512'(8'h01));
        chk("s_eol", 512'(mask_of(base, 8, 2)), 512'(8'h80));
        chk("s_eob", 512'(mask_of(base, 8, 4)), 512'(8'h80));
        chk("s_data5", 512'(obs_q[base + 5].d0), 512'((t0 + 5) * NL));

        // Batch of three, continuous, then with 30% bubbles
        for (int pass = 0; pass < 2; pass++) begin
            run_batch(2, (pass == 0) ? 100 : 30, -1, -1, base);
            step();
            chk("b_count", 512'(obs_q.size() - base), 512'(24));
            chk("b_sob", 512'(mask_of(base, 24, 5)), 512'(24'h000001));
            chk("b_eob", 512'(mask_of(base, 24, 4)), 512'(24'h800000));
            chk("b_sol", 512'(mask_of(base, 24, 3)), 512'(24'h010101));
            chk("b_sos", 512'(mask_of(base, 24, 1)), 512'(24'h111111));
            chk("b_eos", 512'(mask_of(base, 24, 0)), 512'(24'h888888));
            chk("b_pbs7",  512'(obs_q[base + 7].pbs),  512'(0));
            chk("b_pbs8",  512'(obs_q[base + 8].pbs),  512'(1));
            chk("b_pbs16", 512'(obs_q[base + 16].pbs), 512'(2));
            chk("b_pbs23", 512'(obs_q[base + 23].pbs), 512'(2));
        end

        // Command pulsed mid-run is ignored; command held from eob chains
        run_batch(0, 100, 3, 1, base);
        run_batch(1, 100, -1, -1, base2);
        step();
        chk("c_first_len", 512'(base2 - base), 512'(8));
        chk("c_first_eob", 512'(mask_of(base, 8, 4)), 512'(8'h80));
        chk("c_next_sob",  512'(obs_q[base2].fl[5]), 512'(1));
        chk("c_next_len",  512'(obs_q.size() - base2), 512'(16));
        chk("c_next_eob",  512'(mask_of(base2, 16, 4)), 512'(16'h8000));

        // Reset in the middle of a batch
        ntw.cmd_vld = 1'b1; ntw.cmd_pbs_nb_m1 = BPBS_ID_W'(2);
        step();
        ntw.cmd_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ntw.in_vld = 1'b1;
            for (int l = 0; l < NL; l++) ntw.in_data[l] = OP_W'(tag * NL + l + 1);
            tag++;
            step();
        end
        a_rst = 1'b1;
        #1;
        chk("mr_avail", 512'(ntw.out_avail),  512'(0));
        chk("mr_flags", 512'(flags_of(1'b0)), 512'(0));
        chk("mr_data",  512'(ntw.out_data),   512'(0));
        chk("mr_pbs",   512'(ntw.out_pbs_id), 512'(0));
        chk("mr_busy",  512'(ntw.busy),       512'(0));
        ntw.in_vld = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b0;
        step();
        step();
        run_batch(0, 100, -1, -1, base);
        step();
        chk("mr_restart_len", 512'(obs_q.size() - base), 512'(8));
        chk("mr_restart_sob", 512'(mask_of(base, 8, 5)), 512'(8'h01));

        // Degenerate sizes: one beat carries every flag
        deg.cmd_vld = 1'b1; deg.cmd_pbs_nb_m1 = '0;
        step();
        deg.cmd_vld = 1'b0;
        deg.in_vld  = 1'b1;
        for (int l = 0; l < NL; l++) deg.in_data[l] = OP_W'(16'hA0 + l);
        step();
        deg.in_vld = 1'b0;
        chk("d_avail",   512'(deg.out_avail),  512'({NL{1'b1}}));
        chk("d_flags",   512'(flags_of(1'b1)), 512'(6'h3F));
        chk("d_busy",    512'(deg.busy),       512'(0));
        chk("d_cmd_rdy", 512'(deg.cmd_rdy),    512'(1));
        step();
        chk("d_gap_avail", 512'(deg.out_avail),     512'(0));
        chk("d_gap_flags", 512'(flags_of(1'b1)),    512'(0));
        chk("d_gap_data",  512'(deg.out_data[1]),   512'(16'hA1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d cycles required=finish", cycle);
        $fatal(1);
    end

endmodule

`default_nettype wire
